// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode FIFO: DEPTH entries of {pc_plus_four, instruction} decoupling fetch
// from decode stalls, with stall-masked flush and a NOP bubble when empty.
module fetch_decode_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  StallD,
  input  logic                  push_F,
  input  logic [PC_WIDTH-1:0]   pc_plus_four_F,
  input  logic [DATA_WIDTH-1:0] instruction_F,
  output logic                  full_F,
  output logic                  valid_D,
  output logic [PC_WIDTH-1:0]   pc_plus_four_D,
  output logic [DATA_WIDTH-1:0] instruction_D,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: fetch offers an entry with push_F and it is accepted on the edge only
  // when full_F is low (full_F is the inverse of ready and depends on count alone);
  // decode sees valid_D and consumes the head on the edge when StallD is low.

  logic [PC_WIDTH-1:0]   pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q,  count_d;

  logic flush_eff;
  logic pop;
  logic push_ok;

  assign valid_D = (count_q != '0);
  assign full_F  = (count_q == CNT_WIDTH'(DEPTH));
  assign count   = count_q;

  // A flush while decode is stalled is dropped, not deferred.
  assign flush_eff = clear & ~StallD;
  assign pop       = valid_D & ~StallD & ~flush_eff;
  assign push_ok   = push_F & ~full_F & ~flush_eff;

  assign pc_plus_four_D = valid_D ? pc_mem_q[rd_ptr_q]    : '0;
  assign instruction_D  = valid_D ? instr_mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_eff) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count alone decides which slots are meaningful.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      pc_mem_q[wr_ptr_q]    <= pc_plus_four_F;
      instr_mem_q[wr_ptr_q] <= instruction_F;
    end
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Parametrised successor to the single-entry IF/ID register: a DEPTH-entry FIFO between fetch and decode holding {pc_plus_four, instruction} pairs with per-entry valid tracking.
- Decouples fetch from decode stalls so fetch can keep running while decode is stalled, until the queue fills.
- Supports branch/jump flush of all queued wrong-path entries, keeping the stall-masked flush rule of the existing pipeline register.
- Empty queue presents a NOP bubble to decode.

Parameters:
- DATA_WIDTH, 32, width of instruction field.
- PC_WIDTH, 32, width of pc_plus_four field.
- DEPTH, 4, number of entries; power of two, 2..16.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- clear  in  1  flush request (pc_src_D taken); masked by StallD.
- StallD  in  1  decode stalled; head entry must not be consumed.
- push_F  in  1  fetch has a valid pc_plus_four_F/instruction_F this cycle.
- pc_plus_four_F  in  PC_WIDTH  fetched PC+4.
- instruction_F  in  DATA_WIDTH  fetched instruction.
- full_F  out  1  queue full; fetch must stall PC (StallF).
- valid_D  out  1  head entry valid.
- pc_plus_four_D  out  PC_WIDTH  head PC+4, or 0 when empty.
- instruction_D  out  DATA_WIDTH  head instruction, or 0 (NOP) when empty.
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap) and count register. No separate valid array; validity derives from count.
- Reset (synchronous, highest priority): wr_ptr=0, rd_ptr=0, count=0. Storage contents are don't-care. Outputs read valid_D=0, full_F=0, count=0, pc_plus_four_D=0, instruction_D=0.
- Effective flush: flush_eff = clear & !StallD. clear while StallD=1 is ignored, not remembered; decode re-asserts clear after the stall lifts.
- flush_eff (below reset in priority): next edge sets wr_ptr=rd_ptr=0 and count=0. Any same-cycle push_F is dropped. The head entry is consumed (discarded).
- pop = valid_D & !StallD & !flush_eff.
- push_ok = push_F & !full_F & !flush_eff. Push while full_F=1 is ignored even if a pop occurs the same cycle. full_F depends on count only, so there is no combinational path from StallD.
- Next-state on each edge:
  - push_ok: write at wr_ptr, wr_ptr+1.
  - pop: rd_ptr+1.
  - count += push_ok - pop. Simultaneous push_ok and pop leaves count unchanged.
- Latency: an entry pushed at edge N is visible at the D outputs after edge N (one-cycle latency, identical to the old register). There is no combinational fetch-to-decode bypass.
- Outputs (combinational from state):
  - valid_D = (count != 0).
  - full_F = (count == DEPTH).
  - D data = storage[rd_ptr] when valid_D, else all zeros.
- Ordering is strict FIFO. Entries are never reordered or duplicated.
- StallD=1 with valid_D=1: head outputs are held stable. Pushes continue until full.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows (pop requires valid_D).
- Reset asserted mid-operation discards all entries on that edge regardless of clear, StallD or push_F.

Test Plan:
- Reset, then push_F=1 with (pc 0x04, instr 0x8C010000) and StallD=0 -> valid_D=0 in the push cycle; next cycle valid_D=1, pc_plus_four_D=0x04, instruction_D=0x8C010000, count=1.
- StallD=1, push 4 entries (pc 0x04/0x08/0x0C/0x10), DEPTH=4 -> count=4, full_F=1, head stays 0x04; a 5th push (0x14) is ignored. Release StallD -> heads appear in order 0x04, 0x08, 0x0C, 0x10, then valid_D=0 with zero outputs.
- count=2, StallD=0, push and pop in the same cycle repeatedly for 10 cycles -> count stays 2, FIFO order preserved across pointer wrap.
- count=3, StallD=1, clear=1 -> no change (count=3, head unchanged). Next cycle StallD=0, clear=1 with push_F=1 -> count=0, valid_D=0, push dropped, instruction_D=0.
- full queue with StallD=0, push_F=1 (full_F=1) -> pop occurs, push ignored, count=3, full_F=0.
- count=3, reset=1 together with push_F=1 and clear=0 -> count=0, valid_D=0, full_F=0 next cycle; a subsequent push is read from pointer 0.
